// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Programmable interval-timer controller. It owns a BW-bit
//               up-counter and sequences it with a four-state FSM
//               (IDLE, ARMED, RUN, DONE). A valid/ready handshake loads the
//               terminal value, the mode and the prescale value. Start and
//               stop commands move the FSM. The block emits one tick pulse
//               per completed period and a done level in one-shot mode.
//               Optional feature macro: COUNTER_SEQ_PRESCALE_EN. When it is
//               defined, a PW-bit prescaler gates the counter so that the
//               counter advances once every S+1 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
    parameter int BW = 4,
    parameter int PW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfgValid_i,
    output logic          cfgReady_o,
    input  logic [BW-1:0] cfgPeriod_i,
    input  logic          cfgOneShot_i,
    input  logic [PW-1:0] cfgPrescale_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic [BW-1:0] count_o,
    output logic          tick_o,
    output logic          done_o,
    output logic          busy_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [BW-1:0] c_count_zero = '0;
    localparam logic [BW-1:0] c_count_one  = BW'(1);

    state_t        r_state;
    logic [BW-1:0] r_count;
    logic [BW-1:0] r_period;
    logic          r_oneshot;
    logic          r_tick;
    logic          r_done;

    logic          w_cfg_xfer;
    logic          w_terminal;
    logic          w_en;

    // Config is only accepted while the timer is not counting
    assign cfgReady_o = (r_state == ST_IDLE) || (r_state == ST_ARMED);
    assign w_cfg_xfer = cfgValid_i && cfgReady_o;
    assign w_terminal = (r_count == r_period);

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PW-1:0] r_prescale;
    logic [PW-1:0] r_pre_cnt;

    localparam logic [PW-1:0] c_pre_zero = '0;
    localparam logic [PW-1:0] c_pre_one  = PW'(1);

    // An enabled edge happens when the prescaler has counted S clocks
    assign w_en = (r_pre_cnt == r_prescale);

    // Prescaler runs only in RUN; leaving RUN (stop, done) or entering it
    // from ARMED/DONE always sees a cleared prescaler.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prescale <= c_pre_zero;
            r_pre_cnt  <= c_pre_zero;
        end else begin
            if (w_cfg_xfer) begin
                r_prescale <= cfgPrescale_i;
            end
            if ((r_state == ST_RUN) && !stop_i) begin
                r_pre_cnt <= w_en ? c_pre_zero : (r_pre_cnt + c_pre_one);
            end else begin
                r_pre_cnt <= c_pre_zero;
            end
        end
    end
`else
    logic w_unused_prescale;

    // Without the prescaler every RUN edge advances the counter
    assign w_en              = 1'b1;
    assign w_unused_prescale = ^cfgPrescale_i;
`endif

    // Main sequencer: config capture, state transitions and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_count   <= c_count_zero;
            r_period  <= c_count_zero;
            r_oneshot <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Tick is a single-cycle pulse; only a terminal count raises it
            r_tick <= 1'b0;

            // Config latching is independent of the transition chosen below,
            // so a coincident start in ARMED runs with the new config.
            if (w_cfg_xfer) begin
                r_period  <= cfgPeriod_i;
                r_oneshot <= cfgOneShot_i;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_xfer) begin
                        r_state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (stop_i) begin
                        r_state <= ST_IDLE;
                        r_count <= c_count_zero;
                    end else if (start_i) begin
                        r_state <= ST_RUN;
                        r_count <= c_count_zero;
                    end
                end

                ST_RUN: begin
                    // Stop beats a coincident terminal count: no tick issued
                    if (stop_i) begin
                        r_state <= ST_IDLE;
                        r_count <= c_count_zero;
                        r_done  <= 1'b0;
                    end else if (w_en) begin
                        if (w_terminal) begin
                            r_tick <= 1'b1;
                            if (r_oneshot) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_count <= c_count_zero;
                            end
                        end else begin
                            r_count <= r_count + c_count_one;
                        end
                    end
                end

                ST_DONE: begin
                    if (stop_i) begin
                        r_state <= ST_IDLE;
                        r_count <= c_count_zero;
                        r_done  <= 1'b0;
                    end else if (start_i) begin
                        r_state <= ST_RUN;
                        r_count <= c_count_zero;
                        r_done  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_count <= c_count_zero;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count_o = r_count;
    assign tick_o  = r_tick;
    assign done_o  = r_done;
    assign busy_o  = (r_state == ST_RUN);
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Self-checking bench for counter_sequencer. A behavioural model
//               tracks elapsed clocks in RUN and derives count, tick and done
//               from modular arithmetic on that elapsed count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_period;
    logic       cfg_one;
    logic [3:0] cfg_pre;
    logic       start;
    logic       stop;
    logic [3:0] count;
    logic       tick;
    logic       done;
    logic       busy;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_state, m_p, m_one, m_s, m_c, m_count, m_tick, m_done;

    counter_sequencer #(.BW(4), .PW(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfgValid_i   (cfg_valid),
        .cfgReady_o   (cfg_ready),
        .cfgPeriod_i  (cfg_period),
        .cfgOneShot_i (cfg_one),
        .cfgPrescale_i(cfg_pre),
        .start_i      (start),
        .stop_i       (stop),
        .count_o      (count),
        .tick_o       (tick),
        .done_o       (done),
        .busy_o       (busy),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int prescale_div();
`ifdef COUNTER_SEQ_PRESCALE_EN
        return m_s + 1;
`else
        return 1;
`endif
    endfunction

    // Model: m_c counts clocks spent in RUN since the last start; enabled
    // edges are m_c/div and the period boundary is a multiple of P+1.
    task automatic model_step();
        bit xfer;
        int div;
        int e;
        m_tick = 0;
        if (rst) begin
            m_state = 0; m_count = 0; m_done = 0;
            m_p = 0; m_one = 0; m_s = 0; m_c = 0;
            return;
        end
        xfer = cfg_valid && (m_state <= 1);
        if (xfer) begin
            m_p = int'(cfg_period); m_one = int'(cfg_one); m_s = int'(cfg_pre);
        end
        case (m_state)
            0: if (xfer) m_state = 1;
            1: begin
                if (stop) m_state = 0;
                else if (start) begin m_state = 2; m_c = 0; m_count = 0; end
            end
            2: begin
                if (stop) begin
                    m_state = 0; m_count = 0; m_done = 0;
                end else begin
                    m_c++;
                    div = prescale_div();
                    if (m_c % div == 0) begin
                        e = m_c / div;
                        if (e % (m_p + 1) == 0) begin
                            m_tick = 1;
                            if (m_one != 0) begin
                                m_state = 3; m_count = m_p; m_done = 1;
                            end else begin
                                m_count = 0;
                            end
                        end else begin
                            m_count = e % (m_p + 1);
                        end
                    end
                end
            end
            default: begin
                if (stop) begin
                    m_state = 0; m_count = 0; m_done = 0;
                end else if (start) begin
                    m_state = 2; m_c = 0; m_count = 0; m_done = 0;
                end
            end
        endcase
    endtask

    // One clock: advance the model at the edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_cfg(input int p, input int one, input int s);
        cfg_valid = 1'b1; cfg_period = 4'(p); cfg_one = 1'(one); cfg_pre = 4'(s);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; cfg_valid = 1'b1;
        step();
        step();
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++;
        if (tick !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick_done got=%b%b exp=00", tick, done);
        end
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_busy got=%b%b exp=10", cfg_ready, busy);
        end
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        step();
    endtask

    task automatic test_periodic();
        int ticks = 0;
        do_cfg(5, 0, 0);
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL per_armed got=%0d exp=1", state); end
        do_start();
        n_checks++;
        if (count !== 4'd0 || state !== 2'd2) begin
            n_fail++; $display("FAIL per_start got=%0d/%0d exp=0/2", count, state);
        end
        for (int i = 1; i <= 18; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            n_checks++;
            if (count !== 4'(i % 6) || tick !== ((i % 6) == 0)) begin
                n_fail++; $display("FAIL per_seq cyc=%0d got=%0d/%b exp=%0d/%b",
                                   i, count, tick, i % 6, (i % 6) == 0);
            end
        end
        n_checks++;
        if (ticks != 3 || done !== 1'b0) begin
            n_fail++; $display("FAIL per_ticks got=%0d/%b exp=3/0", ticks, done);
        end
        do_stop();
    endtask

    task automatic test_oneshot();
        int ticks = 0;
        do_cfg(3, 1, 0);
        do_start();
        for (int i = 1; i <= 6; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            n_checks++;
            if (count !== 4'(m_count) || tick !== 1'(m_tick)) begin
                n_fail++; $display("FAIL os_seq cyc=%0d got=%0d/%b exp=%0d/%0d",
                                   i, count, tick, m_count, m_tick);
            end
        end
        n_checks++;
        if (ticks != 1 || state !== 2'd3 || done !== 1'b1 || count !== 4'd3) begin
            n_fail++; $display("FAIL os_done got=%0d/%0d/%b/%0d exp=1/3/1/3",
                               ticks, state, done, count);
        end
        do_start();
        n_checks++;
        if (count !== 4'd0 || done !== 1'b0 || state !== 2'd2) begin
            n_fail++; $display("FAIL os_restart got=%0d/%b/%0d exp=0/0/2", count, done, state);
        end
        do_stop();
    endtask

    task automatic test_boundaries();
        do_cfg(15, 0, 0);
        do_start();
        for (int i = 1; i <= 32; i++) begin
            step();
            n_checks++;
            if (count !== 4'(i % 16) || tick !== ((i % 16) == 0)) begin
                n_fail++; $display("FAIL p15 cyc=%0d got=%0d/%b exp=%0d/%b",
                                   i, count, tick, i % 16, (i % 16) == 0);
            end
        end
        do_stop();
        do_cfg(0, 0, 0);
        do_start();
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (count !== 4'd0 || tick !== 1'b1) begin
                n_fail++; $display("FAIL p0 cyc=%0d got=%0d/%b exp=0/1", i, count, tick);
            end
        end
        cfg_valid = 1'b1; cfg_period = 4'd7; cfg_one = 1'b0; cfg_pre = 4'd0;
        n_checks++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready got=%b exp=0", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (count !== 4'd0 || tick !== 1'b1 || state !== 2'd2) begin
                n_fail++; $display("FAIL run_cfg_ignored got=%0d/%b/%0d exp=0/1/2", count, tick, state);
            end
        end
        do_stop();
    endtask

    task automatic test_priority();
        do_cfg(5, 0, 0);
        do_start();
        step();
        step();
        n_checks++;
        if (count !== 4'd2) begin n_fail++; $display("FAIL pri_pre got=%0d exp=2", count); end
        do_stop();
        n_checks++;
        if (state !== 2'd0 || count !== 4'd0 || tick !== 1'b0) begin
            n_fail++; $display("FAIL pri_stop got=%0d/%0d/%b exp=0/0/0", state, count, tick);
        end
        do_cfg(3, 0, 0);
        do_start();
        step(); step(); step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (tick !== 1'b0 || state !== 2'd0) begin
            n_fail++; $display("FAIL pri_stop_term got=%b/%0d exp=0/0", tick, state);
        end
        do_cfg(3, 0, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL pri_start_stop got=%0d exp=0", state); end
        do_cfg(9, 0, 0);
        cfg_valid = 1'b1; cfg_period = 4'd1; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL pri_cfg_start got=%0d exp=2", state); end
        step();
        step();
        n_checks++;
        if (count !== 4'd0 || tick !== 1'b1) begin
            n_fail++; $display("FAIL pri_new_p got=%0d/%b exp=0/1", count, tick);
        end
        do_stop();
    endtask

    task automatic test_prescale();
        int ticks = 0;
        int exp_ticks;
`ifdef COUNTER_SEQ_PRESCALE_EN
        exp_ticks = 2;
`else
        exp_ticks = 8;
`endif
        do_cfg(2, 0, 3);
        do_start();
        for (int i = 1; i <= 24; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            n_checks++;
            if (count !== 4'(m_count) || tick !== 1'(m_tick)) begin
                n_fail++; $display("FAIL pre_seq cyc=%0d got=%0d/%b exp=%0d/%0d",
                                   i, count, tick, m_count, m_tick);
            end
        end
        n_checks++;
        if (ticks != exp_ticks) begin n_fail++; $display("FAIL pre_ticks got=%0d exp=%0d", ticks, exp_ticks); end
        do_stop();
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_period = 4'($urandom_range(0, 6));
            cfg_one    = 1'($urandom_range(0, 1));
            cfg_pre    = 4'($urandom_range(0, 2));
            start      = ($urandom_range(0, 3) == 0);
            stop       = ($urandom_range(0, 11) == 0);
            step();
            got = {state, count, tick, done, busy, cfg_ready};
            exp = {2'(m_state), 4'(m_count), 1'(m_tick), 1'(m_done),
                   (m_state == 2), (m_state <= 1)};
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL rand cyc=%0d got=%b exp=%b", i, got, exp);
            end
        end
        rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        do_stop();
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_one = 1'b0;
        cfg_pre = '0; start = 1'b0; stop = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_boundaries();
        test_priority();
        test_prescale();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Programmable interval-timer controller that owns and sequences a BW-bit up-counter.
- A config handshake loads the terminal value and mode; start/stop commands drive a 4-state FSM.
- Emits per-period tick pulses and a one-shot done flag.
- Sits between control logic (CPU regs / test harness) and any logic needing periodic events derived from the counter.

Parameters:
- BW, 4: counter/period width in bits.
- PW, 4: prescaler width in bits; used only with the optional feature.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cfgValid_i  in  1  config request.
- cfgReady_o  out  1  config accept; combinational from state.
- cfgPeriod_i  in  BW  terminal value P.
- cfgOneShot_i  in  1  1 = one-shot, 0 = periodic.
- cfgPrescale_i  in  PW  prescale value S; ignored without the macro.
- start_i  in  1  start/restart command.
- stop_i  in  1  abort command.
- count_o  out  BW  current counter value (registered).
- tick_o  out  1  one-cycle pulse per completed period (registered).
- done_o  out  1  level; one-shot completed.
- busy_o  out  1  high while in RUN.
- state_o  out  2  FSM state: IDLE=0, ARMED=1, RUN=2, DONE=3.

Behaviour:
- Reset (rst_i high at an edge): state IDLE, count_o=0, tick_o=0, done_o=0, period reg=0, mode reg=0, prescale reg=0. rst_i dominates all other inputs.
- cfgReady_o = 1 in IDLE and ARMED, 0 in RUN and DONE.
- Config transfer occurs when cfgValid_i && cfgReady_o at an edge: latch P, mode and S; next state ARMED. Reconfiguring while in ARMED is allowed and overwrites the previous config.
- IDLE:
  - Config transfer -> ARMED.
  - start_i and stop_i are ignored.
- ARMED:
  - stop_i -> IDLE.
  - Otherwise start_i -> RUN, count<=0.
  - If a config transfer and start_i occur at the same edge, the new config is latched and start is honoured using the new config.
- RUN, on each enabled edge:
  - count==P, periodic: count<=0, tick_o<=1.
  - count==P, one-shot: count holds P, tick_o<=1, done_o<=1, next state DONE.
  - Otherwise: count<=count+1, tick_o<=0.
  - Period is therefore P+1 enabled cycles. P=0 gives a tick every enabled cycle with count staying 0. P=2^BW-1 wraps through the full range.
  - stop_i -> IDLE, count<=0, tick_o<=0. stop_i wins over a coincident terminal count, so no tick is issued.
  - start_i is ignored.
- DONE:
  - done_o stays 1 and count holds P.
  - stop_i -> IDLE.
  - Otherwise start_i -> RUN, count<=0, done_o<=0, reusing the latched config.
- stop_i has priority over start_i in every state.
- tick_o is 0 in every state except the cycle after a terminal count.
- Leaving RUN or DONE for IDLE clears count_o and done_o.
- busy_o = (state==RUN).
- Synchronous reset mid-RUN aborts immediately, with no tick.

Optional Feature:
Macro: COUNTER_SEQ_PRESCALE_EN
- Defined:
  - A PW-bit prescaler gates the counter: an "enabled edge" in RUN occurs once every S+1 clocks.
  - The prescaler clears on start and stop.
  - tick_o is still one clk_i cycle wide.
  - Period = (P+1)*(S+1) clocks.
- Undefined:
  - Every RUN edge is enabled.
  - cfgPrescale_i is unused but remains a port.
  - No prescaler registers are built.

Test Plan:
- Reset: rst_i=1 for 2 cycles with start_i=1, cfgValid_i=1 -> state_o=0, count_o=0, tick_o=0, done_o=0, cfgReady_o=1, busy_o=0.
- Periodic, BW=4, P=5: config, then start -> count_o sequence 0,1,2,3,4,5,0,...; tick_o pulses at cycle 6, 12, 18 after start; exactly 3 ticks in 18 cycles; done_o stays 0.
- One-shot, P=3: start -> count_o 0,1,2,3, then holds 3; state_o=3, done_o=1, exactly one tick. A second start -> count_o restarts at 0 and done_o drops to 0.
- Boundaries:
  - P=15: count_o reaches 15 then 0, with a tick every 16 cycles.
  - P=0: tick_o=1 every cycle, count_o=0.
  - Config while RUN: cfgReady_o=0 and the config is not taken.
- Priority:
  - stop_i at count_o=2 -> IDLE, count_o=0, no tick.
  - stop_i coincident with count_o==P -> no tick.
  - start_i+stop_i together in ARMED -> IDLE.
  - Config+start together in ARMED -> RUN with the new P.
- Prescale (macro defined), P=2, S=3: tick every 12 clocks, count_o changes every 4 clocks. Same stimulus with macro undefined -> tick every 3 clocks.
